axi4lite_rr_master: RTL and testbench
=====================================

# axi4lite_rr_master

Two-requester AXI4-Lite master with round-robin arbitration. It shares one AXI4-Lite slave port, such as the four-register `axi4litetest` peripheral, between two in-fabric requesters. Each requester uses a simple req/ack interface. The block serialises accesses, issues single-beat AXI4-Lite reads and writes, and returns read data and response per requester.

## Interface
- `C_ADDR_WIDTH`, 4, byte-address width of the slave window (4 regs × 4 B)
- `C_DATA_WIDTH`, 32, data width; only 32 is supported
- `ACLK` in 1: single clock; all logic is on the rising edge
- `ARESET` in 1: reset, synchronous and active-high
- `REQ0`/`REQ1` in 1: transaction request; held with WE/ADDR/WDATA until ACK
- `WE0`/`WE1` in 1: 1 = write, 0 = read
- `ADDR0`/`ADDR1` in C_ADDR_WIDTH: byte address; bits [1:0] ignored
- `WDATA0`/`WDATA1` in 32: write data
- `ACK0`/`ACK1` out 1: one-cycle completion pulse
- `RDATA0`/`RDATA1` out 32: read data, valid while ACK is high; held until that requester's next ACK
- `RESP0`/`RESP1` out 2: BRESP/RRESP of the completed transaction, valid with ACK
- `GRANT` out 2: one-hot owner of the current transaction; 00 when idle
- `BUSY` out 1: high in any state other than IDLE
- `M_AXI_AWADDR` out C_ADDR_WIDTH, `M_AXI_AWPROT` out 3, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1
- `M_AXI_ARADDR` out C_ADDR_WIDTH, `M_AXI_ARPROT` out 3, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1

## Operation
- **States:** IDLE, WR_ADDR (AW and W phases), WR_RESP, RD_ADDR, RD_DATA, ACK.
- **IDLE:**
  - Samples REQ0 and REQ1 every cycle.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester that was not last granted wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - On grant: latch WE/ADDR/WDATA, update `last_grant`, set GRANT, then go to WR_ADDR (WE=1) or RD_ADDR (WE=0).
- **WR_ADDR:**
  - AWVALID and WVALID are asserted together on entry.
  - Each is deasserted independently on its own handshake, tracked by internal `aw_done`/`w_done` flags.
  - Go to WR_RESP once both are done; this includes the case where both handshakes land in the same cycle.
- **WR_RESP:** BREADY=1. On BVALID, capture BRESP and go to ACK.
- **RD_ADDR:** ARVALID=1 until ARREADY, then go to RD_DATA.
- **RD_DATA:** RREADY=1. On RVALID, capture RDATA/RRESP into the granted requester's RDATA/RESP, then go to ACK.
- **ACK:**
  - ACKn=1 for the granted requester for exactly one cycle.
  - Next state is IDLE; REQ is not sampled in ACK.
- **Fixed AXI outputs:**
  - AWADDR/ARADDR = latched address with bits [1:0] forced to 0.
  - AWPROT = ARPROT = 3'b000.
  - WSTRB = 4'hF.
- **Stability:** all AXI payload outputs are registered and stay stable while their VALID is high.
- **Slave responses:** passed through unmodified, including SLVERR/DECERR. No retry, no timeout.
- **Reset:**
  - Reset mid-transaction returns to IDLE on the next edge.
  - All VALID/READY outputs, ACKs and GRANT go to 0; no ACK is issued for the aborted transaction.
  - `last_grant` returns to 1.
- **Reset values:** every output is 0 (ACKx, RDATAx, RESPx, GRANT, BUSY, all AXI outputs).

## Timing
- **Zero-wait slave, write:**
  - Grant edge E0.
  - AW/W valid in cycle 1; B handshake in cycle 2 (BVALID may already be high on entry).
  - ACK in cycle 3; IDLE in cycle 4; next grant at the end of cycle 4.
- **Zero-wait slave, read:** AR in cycle 1, R in cycle 2, ACK in cycle 3.
- **Throughput:** at most one transaction per 4 cycles.
- **Requester rule:** to avoid a duplicate grant, a requester must drop REQ in the cycle after its ACK. A registered requester reacting to ACK does this naturally.
- **Wait states:** every AXI wait-state cycle adds exactly one cycle of latency.

## Test plan
1. **Single write, zero-wait slave.** After reset, REQ0 write addr 0x6, data 0x00000002. Required: AWADDR=0x4, WDATA=0x2, WSTRB=0xF. ACK0 high exactly 3 cycles after the grant edge, one cycle wide, RESP0=00. ACK1 never asserted.
2. **Contention.** REQ0 and REQ1 both held high, each issuing 4 writes to 0x0..0xC. Required: GRANT sequence 01,10,01,10,…; no requester is granted twice in a row while the other waits.
3. **Independent AW/W backpressure.** AWREADY delayed 3 cycles, WREADY immediate. Required:
   - WVALID high for one cycle only.
   - AWVALID and AWADDR held stable for 4 cycles.
   - BREADY not asserted before the AW handshake.
4. **Delayed read with error response.** RVALID delayed 5 cycles, RDATA=0xDEADBEEF, RRESP=2'b10. Required: RDATA1=0xDEADBEEF, RESP1=10, single-cycle ACK1, RREADY low outside RD_DATA.
5. **Reset mid-write.** ARESET asserted while AWVALID=1. Required:
   - The next cycle has all AXI valids, ACKs, GRANT and BUSY at 0.
   - After release with both REQ high, requester 0 is granted first.
6. **Register round trip.** Via REQ1, write 1,2,3,4 to 0x0,0x4,0x8,0xC on the four-register slave; then read back via REQ0. Required: RDATA0 equals 1,2,3,4 in order, all RESP=00.

Source files
------------

// File: rtl/axi4lite_rr_master.sv
// axi4lite_rr_master: shares one AXI4-Lite slave port between two req/ack
// requesters. Accesses are serialised, single-beat, and arbitrated round-robin.
module axi4lite_rr_master #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // requester 0
    input  logic                      REQ0,
    input  logic                      WE0,
    input  logic [C_ADDR_WIDTH-1:0]   ADDR0,
    input  logic [C_DATA_WIDTH-1:0]   WDATA0,
    output logic                      ACK0,
    output logic [C_DATA_WIDTH-1:0]   RDATA0,
    output logic [1:0]                RESP0,
    // requester 1
    input  logic                      REQ1,
    input  logic                      WE1,
    input  logic [C_ADDR_WIDTH-1:0]   ADDR1,
    input  logic [C_DATA_WIDTH-1:0]   WDATA1,
    output logic                      ACK1,
    output logic [C_DATA_WIDTH-1:0]   RDATA1,
    output logic [1:0]                RESP1,
    // status
    output logic [1:0]                GRANT,
    output logic                      BUSY,
    // AXI4-Lite master port
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_ACK
    } state_t;

    state_t state, state_next;

    logic                      owner;       // requester of the transaction in flight
    logic                      last_grant;  // requester granted most recently
    logic                      aw_done, w_done;
    logic [C_ADDR_WIDTH-1:0]   addr_q;
    logic [C_DATA_WIDTH-1:0]   wdata_q;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q;

    logic                      grant_any, grant_sel, sel_we;
    logic [C_ADDR_WIDTH-1:0]   sel_addr;
    logic [C_DATA_WIDTH-1:0]   sel_wdata;
    logic                      aw_hs, w_hs;

    // The byte-lane bits of the request address never reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ADDR0[1:0], ADDR1[1:0]};

    // Round-robin pick: a tie goes to the requester that was not granted last.
    always_comb begin
        grant_any = REQ0 | REQ1;
        grant_sel = (REQ0 && REQ1) ? ~last_grant : REQ1;
        sel_we    = grant_sel ? WE1    : WE0;
        sel_addr  = grant_sel ? ADDR1  : ADDR0;
        sel_wdata = grant_sel ? WDATA1 : WDATA0;
    end

    // VALID/READY and status are decodes of registered state and flags.
    assign M_AXI_AWVALID = (state == S_WR_ADDR) && !aw_done;
    assign M_AXI_WVALID  = (state == S_WR_ADDR) && !w_done;
    assign M_AXI_BREADY  = (state == S_WR_RESP);
    assign M_AXI_ARVALID = (state == S_RD_ADDR);
    assign M_AXI_RREADY  = (state == S_RD_DATA);
    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID  && M_AXI_WREADY;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;

    assign BUSY  = (state != S_IDLE);
    assign GRANT = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign ACK0  = (state == S_ACK) && !owner;
    assign ACK1  = (state == S_ACK) &&  owner;

    // State register.
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments so every flop sees pre-edge values.
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so a branch that assigns nothing holds rather than latches.
        state_next = state;
        case (state)
            S_IDLE:    if (grant_any) state_next = sel_we ? S_WR_ADDR : S_RD_ADDR;
            S_WR_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_WR_RESP;
            S_WR_RESP: if (M_AXI_BVALID)  state_next = S_ACK;
            S_RD_ADDR: if (M_AXI_ARREADY) state_next = S_RD_DATA;
            S_RD_DATA: if (M_AXI_RVALID)  state_next = S_ACK;
            S_ACK:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping, request latch, AW/W completion flags and captured responses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            RDATA0     <= '0;
            RDATA1     <= '0;
            RESP0      <= 2'b00;
            RESP1      <= 2'b00;
        end else begin
            if (state == S_IDLE && grant_any) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                addr_q     <= {sel_addr[C_ADDR_WIDTH-1:2], 2'b00};
                wdata_q    <= sel_wdata;
                wstrb_q    <= '1;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (state == S_WR_RESP && M_AXI_BVALID) begin
                if (owner) RESP1 <= M_AXI_BRESP;
                else       RESP0 <= M_AXI_BRESP;
            end
            if (state == S_RD_DATA && M_AXI_RVALID) begin
                if (owner) begin
                    RDATA1 <= M_AXI_RDATA;
                    RESP1  <= M_AXI_RRESP;
                end else begin
                    RDATA0 <= M_AXI_RDATA;
                    RESP0  <= M_AXI_RRESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_rr_master.sv
// Directed bench for axi4lite_rr_master with a four-register AXI4-Lite slave
// model whose ready/valid delays and read response can be set per test.
module tb_axi4lite_rr_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  resp0, resp1;
    logic [1:0]  grant;
    logic        busy;
    logic [3:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    axi4lite_rr_master #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESET(rst),
        .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0),
        .ACK0(ack0), .RDATA0(rdata0), .RESP0(resp0),
        .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1),
        .ACK1(ack1), .RDATA1(rdata1), .RESP1(resp1),
        .GRANT(grant), .BUSY(busy),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot),
        .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
        .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
        .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot),
        .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
    );

    // ---------------- slave model ----------------
    int          aw_delay, w_delay, ar_delay, r_delay;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    bit          ovr_en;
    logic [31:0] ovr_data;
    logic [1:0]  ovr_resp;
    logic [31:0] sregs [4];
    logic        got_aw, got_w, r_pend;
    logic [3:0]  aw_addr_l, s_waddr;
    logic [31:0] w_data_l, s_wdata, r_data_l;
    logic [1:0]  r_resp_l;
    logic        s_aw_hs, s_w_hs, s_ar_hs;

    assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid  && (w_cnt  >= w_delay);
    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign s_aw_hs   = m_awvalid && m_awready;
    assign s_w_hs    = m_wvalid  && m_wready;
    assign s_ar_hs   = m_arvalid && m_arready;
    assign s_waddr   = s_aw_hs ? m_awaddr : aw_addr_l;
    assign s_wdata   = s_w_hs  ? m_wdata  : w_data_l;
    assign m_bresp   = 2'b00;
    assign m_rdata   = r_data_l;
    assign m_rresp   = r_resp_l;

    // Slave: counts wait cycles per channel, stores writes, returns reads.
    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; r_data_l <= '0; r_resp_l <= 2'b00;
            m_bvalid <= 1'b0; m_rvalid <= 1'b0;
            for (int k = 0; k < 4; k++) sregs[k] <= '0;
        end else begin
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid  && !m_wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            if (s_aw_hs) begin got_aw <= 1'b1; aw_addr_l <= m_awaddr; end
            if (s_w_hs)  begin got_w  <= 1'b1; w_data_l  <= m_wdata;  end
            if ((got_aw || s_aw_hs) && (got_w || s_w_hs)) begin
                sregs[s_waddr[3:2]] <= s_wdata;
                m_bvalid <= 1'b1;
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (s_ar_hs) begin
                r_data_l <= ovr_en ? ovr_data : sregs[m_araddr[3:2]];
                r_resp_l <= ovr_en ? ovr_resp : 2'b00;
                if (r_delay == 0) m_rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= 1; end
            end else if (r_pend) begin
                if (r_cnt == r_delay) begin m_rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt + 1;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Per-transaction observations gathered by do_txn.
    int          ack_cyc, aw_cyc, w_cyc, ar_cyc, pay_bad, b_early, r_out, oth_ack;
    logic        ack_after, busy_after;
    logic [1:0]  g1, grant_after, rs;
    logic [31:0] rd;

    // Issue one request from an idle DUT (called at a negedge) and watch it to ACK.
    // Cycle 1 is the cycle after the grant edge.
    task automatic do_txn(input bit who, input bit we, input logic [3:0] addr,
                          input logic [31:0] wd);
        bit aw_s, ar_s, r_s;
        logic [3:0] ea;
        ea = addr & 4'hC;
        aw_s = 0; ar_s = 0; r_s = 0;
        ack_cyc = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        pay_bad = 0; b_early = 0; r_out = 0; oth_ack = 0;
        if (who) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
        else     begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) g1 = grant;
            if (m_awvalid) begin
                aw_cyc++;
                if (m_awaddr !== ea || m_awprot !== 3'b000) pay_bad++;
            end
            if (m_wvalid) begin
                w_cyc++;
                if (m_wdata !== wd || m_wstrb !== 4'hF) pay_bad++;
            end
            if (m_arvalid) begin
                ar_cyc++;
                if (m_araddr !== ea || m_arprot !== 3'b000) pay_bad++;
            end
            if (m_bready && !aw_s) b_early++;
            if (m_rready && !(ar_s && !r_s)) r_out++;
            if (m_awvalid && m_awready) aw_s = 1;
            if (m_arvalid && m_arready) ar_s = 1;
            if (m_rvalid && m_rready)   r_s  = 1;
            if (who ? ack0 : ack1) oth_ack++;
            if (who ? ack1 : ack0) begin
                ack_cyc = c;
                rd = who ? rdata1 : rdata0;
                rs = who ? resp1 : resp0;
                break;
            end
        end
        if (who) req1 = 0; else req0 = 0;
        @(negedge clk);
        ack_after   = who ? ack1 : ack0;
        busy_after  = busy;
        grant_after = grant;
    endtask

    logic [1:0] gseq [8];
    int         ng, i0, i1;
    logic [1:0] pg;
    bit         got0, got1;

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;
        ovr_en = 0; ovr_data = '0; ovr_resp = 2'b00;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ctl", 32'({ack0, ack1, grant, busy, m_awvalid, m_wvalid, m_bready,
                              m_arvalid, m_rready}), 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_resp", 32'({resp0, resp1}), 0);
        check("rst_aw", 32'({m_awaddr, m_awprot, m_wstrb}), 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_ar", 32'({m_araddr, m_arprot}), 0);
        rst = 0;
        @(negedge clk);

        // 1: single write, zero-wait slave
        do_txn(0, 1, 4'h6, 32'h0000_0002);
        check("t1_grant", 32'(g1), 1);
        check("t1_payload", pay_bad, 0);
        check("t1_aw_cycles", aw_cyc, 1);
        check("t1_w_cycles", w_cyc, 1);
        check("t1_ack_cycle", ack_cyc, 3);
        check("t1_ack_width", 32'(ack_after), 0);
        check("t1_resp", 32'(rs), 0);
        check("t1_ack1_never", oth_ack, 0);
        check("t1_idle", 32'({busy_after, grant_after}), 0);

        // 2: contention, both held high for 4 writes each
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        req0 = 1; we0 = 1; addr0 = 4'h0; wdata0 = 32'h100;
        req1 = 1; we1 = 1; addr1 = 4'h0; wdata1 = 32'h200;
        i0 = 0; i1 = 0; ng = 0; pg = 2'b00;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && pg == 2'b00) begin
                if (ng < 8) gseq[ng] = grant;
                ng++;
            end
            pg = grant;
            if (ack0) begin
                i0++;
                if (i0 == 4) req0 = 0;
                else begin addr0 = 4'(i0 * 4); wdata0 = 32'(32'h100 + i0); end
            end
            if (ack1) begin
                i1++;
                if (i1 == 4) req1 = 0;
                else begin addr1 = 4'(i1 * 4); wdata1 = 32'(32'h200 + i1); end
            end
            if (i0 == 4 && i1 == 4) break;
        end
        check("t2_grant_count", ng, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t2_grant%0d", k), 32'(gseq[k]), (k % 2 == 1) ? 2 : 1);
        repeat (2) @(negedge clk);

        // 3: AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3;
        do_txn(0, 1, 4'h8, 32'h0000_0055);
        aw_delay = 0;
        check("t3_w_cycles", w_cyc, 1);
        check("t3_aw_cycles", aw_cyc, 4);
        check("t3_payload_stable", pay_bad, 0);
        check("t3_bready_early", b_early, 0);
        check("t3_ack_cycle", ack_cyc, 6);

        // 4: RVALID delayed 5 cycles, SLVERR response
        r_delay = 5; ovr_en = 1; ovr_data = 32'hDEAD_BEEF; ovr_resp = 2'b10;
        do_txn(1, 0, 4'h4, 32'h0);
        r_delay = 0; ovr_en = 0;
        check("t4_grant", 32'(g1), 2);
        check("t4_rdata1", rd, 32'hDEAD_BEEF);
        check("t4_resp1", 32'(rs), 2);
        check("t4_ack_cycle", ack_cyc, 8);
        check("t4_ack_width", 32'(ack_after), 0);
        check("t4_rready_outside", r_out, 0);
        check("t4_ar_cycles", ar_cyc, 1);
        @(negedge clk);
        check("t4_rdata1_held", rdata1, 32'hDEAD_BEEF);

        // 5: reset while AWVALID is high
        aw_delay = 5;
        req0 = 1; we0 = 1; addr0 = 4'hC; wdata0 = 32'h77;
        @(negedge clk);
        check("t5_awvalid", 32'({m_awvalid, grant}), 32'h5);
        rst = 1; req0 = 0;
        @(negedge clk);
        check("t5_cleared", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                                 ack0, ack1, grant, busy}), 0);
        aw_delay = 0;
        rst = 0;
        req0 = 1; we0 = 0; addr0 = 4'h0;
        req1 = 1; we1 = 0; addr1 = 4'h4;
        @(negedge clk);
        check("t5_first_grant", 32'(grant), 1);
        got0 = 0; got1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (ack0) begin got0 = 1; req0 = 0; end
            if (ack1) begin got1 = 1; req1 = 0; end
            if (got0 && got1) break;
            @(negedge clk);
        end
        check("t5_both_served", 32'({got0, got1}), 3);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // 6: register round trip, write via requester 1, read via requester 0
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 4'(i * 4), 32'(i + 1));
            check($sformatf("t6_wresp%0d", i), 32'(rs), 0);
        end
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 0, 4'(i * 4), 32'h0);
            check($sformatf("t6_rdata%0d", i), rd, 32'(i + 1));
            check($sformatf("t6_rresp%0d", i), 32'(rs), 0);
            check($sformatf("t6_rlat%0d", i), ack_cyc, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
